// File: rtl/axi_ic_slave_arb_rr.sv
// Per-slave burst arbiter: one owner per slave port, held until that owner's last handshake.
// Fixed-priority or round-robin selection, with an optional starvation escape in fixed mode.
module axi_ic_slave_arb_rr #(
  parameter int unsigned MSTRNUM      = 2,
  parameter int unsigned SLVNUM       = 2,
  parameter int unsigned SLV_W        = 1,
  parameter int unsigned ARB_MODE     = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [MSTRNUM-1:0]         M_req,
  input  logic [MSTRNUM-1:0]         M_grant,
  input  logic [MSTRNUM-1:0]         M_last,
  input  logic [MSTRNUM*SLV_W-1:0]   M_slave,
  output logic [SLVNUM*MSTRNUM-1:0]  S_master,
  output logic [SLVNUM-1:0]          S_busy
);

  localparam int unsigned PtrW = (MSTRNUM > 1) ? $clog2(MSTRNUM) : 1;
  localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);
  localparam bit StarveEn = (ARB_MODE == 0) && (STARVE_LIMIT > 0);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;

  for (genvar s = 0; s < SLVNUM; s++) begin : g_slv
    logic [0:0]         state_q, state_d;
    logic [MSTRNUM-1:0] owner_q, owner_d;
    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [MSTRNUM-1:0] cand, arb_cand, pick_fixed, pick_rr, pick;
    logic [PtrW-1:0]    owner_idx;
    logic               done, others, force_rr, arbitrate, found_fx, found_rr;

    always_comb begin
      cand       = '0;
      owner_idx  = '0;
      pick_fixed = '0;
      pick_rr    = '0;
      found_fx   = 1'b0;
      found_rr   = 1'b0;
      for (int m = 0; m < MSTRNUM; m++) begin
        cand[m] = M_req[m] && (M_slave[m*SLV_W +: SLV_W] == SLV_W'(s));
        if (owner_q[m]) owner_idx = PtrW'(m);
      end

      done      = (state_q == OWNED) && |(owner_q & M_req & M_grant & M_last);
      others    = |(cand & ~owner_q);
      // The completing owner never wins its own hand-off.
      arb_cand  = (state_q == OWNED) ? (cand & ~owner_q) : cand;
      arbitrate = (state_q == IDLE) || done;
      force_rr  = StarveEn && (cnt_q == CntMax);

      for (int m = 0; m < MSTRNUM; m++) begin
        if (!found_fx && arb_cand[m]) begin
          pick_fixed[m] = 1'b1;
          found_fx      = 1'b1;
        end
      end
      // Two passes give the wrap-around search starting at ptr_q.
      for (int m = 0; m < MSTRNUM; m++) begin
        if (!found_rr && arb_cand[m] && (PtrW'(m) >= ptr_q)) begin
          pick_rr[m] = 1'b1;
          found_rr   = 1'b1;
        end
      end
      for (int m = 0; m < MSTRNUM; m++) begin
        if (!found_rr && arb_cand[m]) begin
          pick_rr[m] = 1'b1;
          found_rr   = 1'b1;
        end
      end
      pick = ((ARB_MODE == 1) || force_rr) ? pick_rr : pick_fixed;

      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      if (arbitrate) begin
        owner_d = pick;
        state_d = (|pick) ? OWNED : IDLE;
      end
      if (done) begin
        ptr_d = (owner_idx == PtrW'(MSTRNUM - 1)) ? '0 : owner_idx + PtrW'(1);
      end
      if (StarveEn && arbitrate) begin
        if (force_rr && (|pick)) begin
          cnt_d = '0;
        end else if (done && others) begin
          cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
        end else if (done) begin
          cnt_d = '0;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        owner_q <= '0;
        ptr_q   <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q   <= ptr_d;
        cnt_q   <= cnt_d;
      end
    end

    assign S_master[s*MSTRNUM +: MSTRNUM] = owner_q;
    assign S_busy[s]                      = state_q;
  end

endmodule
